// File: rtl/gate_deadtime_sequencer.sv
// Per-leg half-bridge gate sequencer: inserts a fixed dead time before every gate turn-on
// and latches a sticky fault on a shoot-through ({hi,lo}=11) request.
module gate_deadtime_sequencer #(
    parameter int LEGS      = 3,
    parameter int DEAD_TIME = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2*LEGS-1:0] cmd,
    input  logic              fault_clr,
    output logic [2*LEGS-1:0] gate,
    output logic              fault,
    output logic [LEGS-1:0]   dead,
    output logic [2*LEGS-1:0] leg_state
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_DEAD = 2'd1,
        S_ON_H = 2'd2,
        S_ON_L = 2'd3
    } leg_state_e;

    localparam logic [15:0] DT_LOAD  = 16'(DEAD_TIME - 1);
    localparam logic [1:0]  REQ_HIGH = 2'b10;
    localparam logic [1:0]  REQ_LOW  = 2'b01;

    logic illegal_any;

    always_comb begin
        illegal_any = 1'b0;
        for (int k = 0; k < LEGS; k++) begin
            if (cmd[2*k +: 2] == 2'b11) illegal_any = 1'b1;
        end
    end

    // A new shoot-through request wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault <= 1'b0;
        end else if (enable && illegal_any) begin
            fault <= 1'b1;
        end else if (fault_clr) begin
            fault <= 1'b0;
        end
    end

    for (genvar k = 0; k < LEGS; k++) begin : g_leg
        leg_state_e  state;
        logic [15:0] cnt;
        logic [1:0]  g;
        logic        d;
        logic [1:0]  req;

        assign req                 = cmd[2*k +: 2];
        assign gate[2*k +: 2]      = g;
        assign dead[k]             = d;
        assign leg_state[2*k +: 2] = state;

        // Gate and dead flags are updated in lockstep with state, so they always
        // equal the decode of the registered state and hi/lo can never overlap.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= S_OFF;
                cnt   <= '0;
                g     <= 2'b00;
                d     <= 1'b0;
            end else if (!enable || fault) begin
                state <= S_OFF;
                cnt   <= '0;
                g     <= 2'b00;
                d     <= 1'b0;
            end else begin
                case (state)
                    S_OFF: begin
                        if (req == REQ_HIGH || req == REQ_LOW) begin
                            state <= S_DEAD;
                            cnt   <= DT_LOAD;
                            d     <= 1'b1;
                        end
                    end
                    S_ON_H: begin
                        if (req != REQ_HIGH) begin
                            state <= S_DEAD;
                            cnt   <= DT_LOAD;
                            g     <= 2'b00;
                            d     <= 1'b1;
                        end
                    end
                    S_ON_L: begin
                        if (req != REQ_LOW) begin
                            state <= S_DEAD;
                            cnt   <= DT_LOAD;
                            g     <= 2'b00;
                            d     <= 1'b1;
                        end
                    end
                    S_DEAD: begin
                        // Request changes here never reload the counter; only the
                        // request seen on the terminal edge picks the exit state.
                        if (cnt == 16'd0) begin
                            d <= 1'b0;
                            if (req == REQ_HIGH) begin
                                state <= S_ON_H;
                                g     <= 2'b10;
                            end else if (req == REQ_LOW) begin
                                state <= S_ON_L;
                                g     <= 2'b01;
                            end else begin
                                state <= S_OFF;
                                g     <= 2'b00;
                            end
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        cnt   <= '0;
                        g     <= 2'b00;
                        d     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_deadtime_sequencer.sv
// Directed bench for gate_deadtime_sequencer with DEAD_TIME=4, three legs.
module tb_gate_deadtime_sequencer;

    localparam int LEGS = 3;
    localparam int DT   = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [2*LEGS-1:0] cmd;
    logic            fault_clr;
    logic [2*LEGS-1:0] gate;
    logic            fault;
    logic [LEGS-1:0] dead;
    logic [2*LEGS-1:0] leg_state;

    int total = 0;
    int bad   = 0;

    gate_deadtime_sequencer #(.LEGS(LEGS), .DEAD_TIME(DT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .cmd       (cmd),
        .fault_clr (fault_clr),
        .gate      (gate),
        .fault     (fault),
        .dead      (dead),
        .leg_state (leg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        cmd       = '0;
        fault_clr = 1'b0;
        #3;
        total++;
        if (gate !== 6'b000000) begin bad++; $display("FAIL reset_gate got=%b exp=000000", gate); end
        total++;
        if (dead !== 3'b000) begin bad++; $display("FAIL reset_dead got=%b exp=000", dead); end
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        total++;
        if (leg_state !== 6'b000000) begin bad++; $display("FAIL reset_state got=%b exp=000000", leg_state); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (gate !== 6'b000000 || dead !== 3'b000) begin
            bad++; $display("FAIL idle_after_reset gate=%b dead=%b exp=000000/000", gate, dead);
        end
    endtask

    // Leg0 OFF -> ON_H: four dead cycles then high gate.
    task automatic test_turn_on();
        cmd = 6'b000010;
        for (int i = 0; i < DT; i++) begin
            tick();
            total++;
            if (gate[1:0] !== 2'b00 || dead[0] !== 1'b1) begin
                bad++; $display("FAIL turn_on_dead%0d gate=%b dead=%b exp=00/1", i, gate[1:0], dead[0]);
            end
        end
        tick();
        total++;
        if (gate[1:0] !== 2'b10 || dead[0] !== 1'b0) begin
            bad++; $display("FAIL turn_on_hi gate=%b dead=%b exp=10/0", gate[1:0], dead[0]);
        end
    endtask

    // Leg0 ON_H -> ON_L: gate drops on first edge, four dead cycles, then low gate.
    task automatic test_h_to_l();
        cmd = 6'b000001;
        for (int i = 0; i < DT; i++) begin
            tick();
            total++;
            if (gate[1:0] !== 2'b00 || dead[0] !== 1'b1) begin
                bad++; $display("FAIL h_to_l_dead%0d gate=%b dead=%b exp=00/1", i, gate[1:0], dead[0]);
            end
        end
        tick();
        total++;
        if (gate[1:0] !== 2'b01) begin bad++; $display("FAIL h_to_l_on gate=%b exp=01", gate[1:0]); end
    endtask

    // Leg1 request toggles during DEAD: window stays four cycles, exit follows final request.
    task automatic test_dead_toggle();
        logic [1:0] seq [4];
        seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b10;
        for (int i = 0; i < DT; i++) begin
            cmd = {2'b00, seq[i], 2'b01};
            tick();
            total++;
            if (gate[3:2] !== 2'b00 || dead[1] !== 1'b1 || gate[1:0] !== 2'b01) begin
                bad++; $display("FAIL toggle_dead%0d gate=%b dead=%b exp=000001/x1x", i, gate, dead);
            end
        end
        tick();
        total++;
        if (gate !== 6'b001001 || dead !== 3'b000) begin
            bad++; $display("FAIL toggle_exit gate=%b dead=%b exp=001001/000", gate, dead);
        end
    endtask

    task automatic test_fault();
        cmd = '0;
        repeat (6) tick();
        total++;
        if (gate !== 6'b000000 || dead !== 3'b000) begin
            bad++; $display("FAIL fault_pre_idle gate=%b dead=%b exp=000000/000", gate, dead);
        end
        cmd = 6'b000010;
        repeat (5) tick();
        total++;
        if (gate !== 6'b000010) begin bad++; $display("FAIL fault_pre_on gate=%b exp=000010", gate); end
        cmd = 6'b110010;
        tick();
        total++;
        if (fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", fault); end
        tick();
        total++;
        if (gate !== 6'b000000 || dead !== 3'b000) begin
            bad++; $display("FAIL fault_gates_off gate=%b dead=%b exp=000000/000", gate, dead);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if (fault !== 1'b1) begin bad++; $display("FAIL fault_set_wins got=%b exp=1", fault); end
        cmd = '0;
        tick();
        total++;
        if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b exp=1", fault); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if (fault !== 1'b0 || gate !== 6'b000000 || dead !== 3'b000) begin
            bad++; $display("FAIL fault_clear fault=%b gate=%b dead=%b exp=0/000000/000", fault, gate, dead);
        end
        cmd = 6'b000010;
        tick();
        total++;
        if (dead !== 3'b001 || gate !== 6'b000000) begin
            bad++; $display("FAIL fault_reentry dead=%b gate=%b exp=001/000000", dead, gate);
        end
        cmd = '0;
        repeat (5) tick();
    endtask

    task automatic test_async_reset();
        cmd = 6'b000001;
        repeat (5) tick();
        total++;
        if (gate[1:0] !== 2'b01) begin bad++; $display("FAIL ar_pre_on gate=%b exp=01", gate[1:0]); end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (gate !== 6'b000000 || dead !== 3'b000 || fault !== 1'b0) begin
            bad++; $display("FAIL ar_async gate=%b dead=%b fault=%b exp=000000/000/0", gate, dead, fault);
        end
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < DT; i++) begin
            tick();
            total++;
            if (gate[1:0] !== 2'b00 || dead[0] !== 1'b1) begin
                bad++; $display("FAIL ar_dead%0d gate=%b dead=%b exp=00/1", i, gate[1:0], dead[0]);
            end
        end
        tick();
        total++;
        if (gate[1:0] !== 2'b01) begin bad++; $display("FAIL ar_on gate=%b exp=01", gate[1:0]); end
    endtask

    task automatic test_enable();
        cmd = 6'b100110;
        repeat (6) tick();
        total++;
        if (gate !== 6'b100110) begin bad++; $display("FAIL en_all_on gate=%b exp=100110", gate); end
        enable = 1'b0;
        tick();
        total++;
        if (gate !== 6'b000000 || fault !== 1'b0 || dead !== 3'b000) begin
            bad++; $display("FAIL en_off gate=%b fault=%b dead=%b exp=000000/0/000", gate, fault, dead);
        end
        cmd = 6'b101110;
        tick();
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL en_illegal_ignored fault=%b exp=0", fault); end
        cmd    = 6'b100110;
        enable = 1'b1;
        for (int i = 0; i < DT; i++) begin
            tick();
            total++;
            if (gate !== 6'b000000 || dead !== 3'b111) begin
                bad++; $display("FAIL en_dead%0d gate=%b dead=%b exp=000000/111", i, gate, dead);
            end
        end
        tick();
        total++;
        if (gate !== 6'b100110 || dead !== 3'b000) begin
            bad++; $display("FAIL en_reon gate=%b dead=%b exp=100110/000", gate, dead);
        end
    endtask

    initial begin
        test_reset();
        test_turn_on();
        test_h_to_l();
        test_dead_toggle();
        test_fault();
        test_async_reset();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
